// File: rtl/ps2pl_axis_bit_serializer.sv
// Serialises 32-bit ps2pl AXI-Stream words into a bit stream, with each bit held for SAMPLES_PER_SYMBOL clocks.
// Optional build macro MOD_PREAMBLE_EN sends PREAMBLE_WORD before each frame.
module ps2pl_axis_bit_serializer #(
    parameter int          SAMPLES_PER_SYMBOL = 16,
    parameter bit          MSB_FIRST          = 1'b0,
    parameter logic [31:0] PREAMBLE_WORD      = 32'hAAAA_AAAB
) (
    input  logic        dac_dco_clk,
    input  logic        mod_reset,
    input  logic [31:0] ps2pl_fifo_m_axis_tdata,
    input  logic [3:0]  ps2pl_fifo_m_axis_tkeep,
    input  logic        ps2pl_fifo_m_axis_tlast,
    input  logic        ps2pl_fifo_m_axis_tvalid,
    output logic        ps2pl_fifo_m_axis_tready,
    input  logic        err_clr,
    output logic        bit_out,
    output logic        sym_strobe,
    output logic        tx_active,
    output logic        frame_done,
    output logic        underrun_err,
    output logic        tkeep_err
);

    localparam int             CW       = $clog2(SAMPLES_PER_SYMBOL);
    localparam logic [CW-1:0]  SYM_LAST = CW'(SAMPLES_PER_SYMBOL - 1);

`ifdef MOD_PREAMBLE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2} state_t;
    logic [31:0] pre_buf;
    logic [5:0]  word_bits;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
    logic unused_preamble;
    assign unused_preamble = ^PREAMBLE_WORD;
`endif

    state_t        state;
    logic [31:0]   word_buf;
    logic [5:0]    bits_left;
    logic [CW-1:0] sym_cnt;
    logic          cur_last;
    logic          take;

    function automatic logic [5:0] kept_bits(input logic [3:0] keep);
        case (keep)
            4'b0001: return 6'd8;
            4'b0011: return 6'd16;
            4'b0111: return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic keep_bad(input logic [3:0] keep);
        case (keep)
            4'b0001, 4'b0011, 4'b0111, 4'b1111: return 1'b0;
            default:                             return 1'b1;
        endcase
    endfunction

    // Drops masked bytes; MSB-first words are left-aligned so the top kept bit leaves first.
    function automatic logic [31:0] load_word(input logic [31:0] data, input logic [3:0] keep);
        logic [5:0]  pad;
        logic [31:0] masked;
        pad    = 6'd32 - kept_bits(keep);
        masked = data & (32'hFFFF_FFFF >> pad);
        return MSB_FIRST ? (masked << pad) : masked;
    endfunction

    function automatic logic first_bit(input logic [31:0] w);
        return MSB_FIRST ? w[31] : w[0];
    endfunction

    function automatic logic [31:0] next_word(input logic [31:0] w);
        return MSB_FIRST ? {w[30:0], 1'b0} : {1'b0, w[31:1]};
    endfunction

    assign ps2pl_fifo_m_axis_tready = !mod_reset &&
        ((state == IDLE) ||
         (state == DATA && bits_left == 6'd1 && sym_cnt == SYM_LAST && !cur_last));
    assign take = ps2pl_fifo_m_axis_tvalid && ps2pl_fifo_m_axis_tready;

    always_ff @(posedge dac_dco_clk) begin
        if (mod_reset) begin
            state        <= IDLE;
            word_buf     <= '0;
            bits_left    <= '0;
            sym_cnt      <= '0;
            cur_last     <= 1'b0;
            bit_out      <= 1'b0;
            sym_strobe   <= 1'b0;
            tx_active    <= 1'b0;
            frame_done   <= 1'b0;
            underrun_err <= 1'b0;
            tkeep_err    <= 1'b0;
`ifdef MOD_PREAMBLE_EN
            pre_buf      <= '0;
            word_bits    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            sym_strobe <= 1'b0;
            // Clear first so a same-cycle set below takes priority.
            if (err_clr) begin
                underrun_err <= 1'b0;
                tkeep_err    <= 1'b0;
            end
            if (take && keep_bad(ps2pl_fifo_m_axis_tkeep))
                tkeep_err <= 1'b1;

            case (state)
                IDLE: begin
                    sym_cnt   <= '0;
                    bit_out   <= 1'b0;
                    tx_active <= 1'b0;
                    if (take) begin
                        word_buf   <= load_word(ps2pl_fifo_m_axis_tdata, ps2pl_fifo_m_axis_tkeep);
                        cur_last   <= ps2pl_fifo_m_axis_tlast;
                        sym_strobe <= 1'b1;
                        tx_active  <= 1'b1;
`ifdef MOD_PREAMBLE_EN
                        pre_buf    <= PREAMBLE_WORD;
                        word_bits  <= kept_bits(ps2pl_fifo_m_axis_tkeep);
                        bits_left  <= 6'd32;
                        bit_out    <= first_bit(PREAMBLE_WORD);
                        state      <= PREAMBLE;
`else
                        bits_left  <= kept_bits(ps2pl_fifo_m_axis_tkeep);
                        bit_out    <= first_bit(load_word(ps2pl_fifo_m_axis_tdata,
                                                          ps2pl_fifo_m_axis_tkeep));
                        state      <= DATA;
`endif
                    end
                end
`ifdef MOD_PREAMBLE_EN
                PREAMBLE: begin
                    if (sym_cnt == SYM_LAST) begin
                        sym_cnt    <= '0;
                        sym_strobe <= 1'b1;
                        if (bits_left == 6'd1) begin
                            state     <= DATA;
                            bits_left <= word_bits;
                            bit_out   <= first_bit(word_buf);
                        end else begin
                            pre_buf   <= next_word(pre_buf);
                            bit_out   <= first_bit(next_word(pre_buf));
                            bits_left <= bits_left - 6'd1;
                        end
                    end else begin
                        sym_cnt <= sym_cnt + CW'(1);
                    end
                end
`endif
                DATA: begin
                    if (sym_cnt == SYM_LAST) begin
                        sym_cnt <= '0;
                        if (bits_left != 6'd1) begin
                            word_buf   <= next_word(word_buf);
                            bit_out    <= first_bit(next_word(word_buf));
                            bits_left  <= bits_left - 6'd1;
                            sym_strobe <= 1'b1;
                        end else if (cur_last) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                            tx_active  <= 1'b0;
                            bit_out    <= 1'b0;
                        end else if (take) begin
                            word_buf   <= load_word(ps2pl_fifo_m_axis_tdata, ps2pl_fifo_m_axis_tkeep);
                            bit_out    <= first_bit(load_word(ps2pl_fifo_m_axis_tdata,
                                                              ps2pl_fifo_m_axis_tkeep));
                            bits_left  <= kept_bits(ps2pl_fifo_m_axis_tkeep);
                            cur_last   <= ps2pl_fifo_m_axis_tlast;
                            sym_strobe <= 1'b1;
                        end else begin
                            underrun_err <= 1'b1;
                            state        <= IDLE;
                            tx_active    <= 1'b0;
                            bit_out      <= 1'b0;
                        end
                    end else begin
                        sym_cnt <= sym_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2pl_axis_bit_serializer.sv
// Bench for ps2pl_axis_bit_serializer: directed and random frames checked against a bit-list model.
`timescale 1ns/1ps
module tb_ps2pl_axis_bit_serializer;

    localparam int SPS = 4;
`ifdef MOD_PREAMBLE_EN
    localparam int PRE_BITS = 32;
`else
    localparam int PRE_BITS = 0;
`endif
    localparam logic [31:0] PRE_WORD = 32'hAAAA_AAAB;

    logic        clk = 1'b0;
    logic        mod_reset = 1'b1;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        err_clr = 1'b0;
    logic        bit_out, sym_strobe, tx_active, frame_done, underrun_err, tkeep_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Observations gathered every negedge.
    bit got_bits[$];
    int done_count = 0, last_done_cyc = 0, act_cycles = 0, rise_cyc = 0;
    int gap_errs = 0, hold_errs = 0, tready_act = 0, strobe_count = 0, last_strobe = 0;
    logic prev_active = 1'b0, prev_bit = 1'b0;

    bit exp_bits[$];

    ps2pl_axis_bit_serializer #(.SAMPLES_PER_SYMBOL(SPS), .MSB_FIRST(1'b0), .PREAMBLE_WORD(PRE_WORD)) dut (
        .dac_dco_clk              (clk),
        .mod_reset                (mod_reset),
        .ps2pl_fifo_m_axis_tdata  (tdata),
        .ps2pl_fifo_m_axis_tkeep  (tkeep),
        .ps2pl_fifo_m_axis_tlast  (tlast),
        .ps2pl_fifo_m_axis_tvalid (tvalid),
        .ps2pl_fifo_m_axis_tready (tready),
        .err_clr                  (err_clr),
        .bit_out                  (bit_out),
        .sym_strobe               (sym_strobe),
        .tx_active                (tx_active),
        .frame_done               (frame_done),
        .underrun_err             (underrun_err),
        .tkeep_err                (tkeep_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_active) begin
            act_cycles <= act_cycles + 1;
            if (!prev_active) begin
                rise_cyc <= cyc;
                if (!sym_strobe) hold_errs <= hold_errs + 1;
            end
            if (sym_strobe) begin
                got_bits.push_back(bit_out);
                if (prev_active && (cyc - last_strobe) != SPS) gap_errs <= gap_errs + 1;
                last_strobe  <= cyc;
                strobe_count <= strobe_count + 1;
            end else if (bit_out !== prev_bit) begin
                hold_errs <= hold_errs + 1;
            end
            if (tready) tready_act <= tready_act + 1;
        end else if (sym_strobe || bit_out) begin
            hold_errs <= hold_errs + 1;
        end
        if (frame_done) begin
            done_count    <= done_count + 1;
            last_done_cyc <= cyc;
        end
        prev_active <= tx_active;
        prev_bit    <= bit_out;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: kept bytes of each word, LSB of byte 0 first; illegal tkeep sends all four bytes.
    function automatic int keptBytes(input logic [3:0] k);
        if (k == 4'b0001) return 1;
        if (k == 4'b0011) return 2;
        if (k == 4'b0111) return 3;
        return 4;
    endfunction

    function automatic bit badKeep(input logic [3:0] k);
        return !(k == 4'b0001 || k == 4'b0011 || k == 4'b0111 || k == 4'b1111);
    endfunction

    task automatic modelFrameStart();
        logic [31:0] p;
        p = PRE_WORD;
        exp_bits.delete();
        for (int i = 0; i < PRE_BITS; i++) exp_bits.push_back(p[i]);
    endtask

    task automatic modelWord(input logic [31:0] d, input logic [3:0] k);
        for (int i = 0; i < 8 * keptBytes(k); i++) exp_bits.push_back(d[i]);
    endtask

    // Called at a negedge; returns at the negedge after the handshake with hs = cycle of first bit.
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic l,
                                 input logic clr, output int hs);
        int waited;
        waited = 0;
        hs = -1;
        tdata = d; tkeep = k; tlast = l; tvalid = 1'b1; err_clr = clr;
        while (tready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (tready !== 1'b1) begin
            checkOutput("handshake_timeout", 32'd0, 32'd1);
            tvalid = 1'b0; err_clr = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            hs = cyc;
            tvalid = 1'b0; err_clr = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic waitFrameEnd();
        int n;
        n = 0;
        while (tx_active === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx_active === 1'b1) checkOutput("frame_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic checkBits(input string tag, input int base);
        int bad, n;
        bad = 0;
        n = got_bits.size() - base;
        checkOutput({tag, "_count"}, 32'(n), 32'(exp_bits.size()));
        for (int i = 0; i < exp_bits.size() && i < n; i++)
            if (got_bits[base + i] !== exp_bits[i]) bad++;
        checkOutput({tag, "_bits"}, 32'(bad), 32'd0);
    endtask

    task automatic clearErrors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hs, hs2, base, d0, a0, t0, s0, n, nw;
        bit bad;
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  keep_opts [6];
        keep_opts = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0101, 4'b0000};

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({bit_out, sym_strobe, tx_active, frame_done, underrun_err, tkeep_err, tready}), 32'd0);
        mod_reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_tready", 32'(tready), 32'd1);
        checkOutput("idle_tx_active", 32'(tx_active), 32'd0);

        // Single byte frame: first bit one cycle after handshake, frame_done right after last period.
        modelFrameStart(); modelWord(32'h0000_00A5, 4'b0001);
        base = got_bits.size(); d0 = done_count; a0 = act_cycles;
        applyStimulus(32'h0000_00A5, 4'b0001, 1'b1, 1'b0, hs);
        waitFrameEnd();
        checkBits("a5", base);
        checkOutput("a5_latency", 32'(rise_cyc), 32'(hs));
        checkOutput("a5_active_cycles", 32'(act_cycles - a0), 32'((PRE_BITS + 8) * SPS));
        checkOutput("a5_done_count", 32'(done_count - d0), 32'd1);
        checkOutput("a5_done_cycle", 32'(last_done_cyc - hs), 32'((PRE_BITS + 8) * SPS));

        // Two-word frame with tvalid held high: seamless reload.
        modelFrameStart(); modelWord(32'hFFFF_FFFF, 4'b1111); modelWord(32'h0000_0000, 4'b1111);
        base = got_bits.size(); d0 = done_count; t0 = tready_act;
        applyStimulus(32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b0, hs);
        applyStimulus(32'h0000_0000, 4'b1111, 1'b1, 1'b0, hs2);
        waitFrameEnd();
        checkBits("two_word", base);
        checkOutput("two_word_tready_cycle", 32'(hs2 - hs), 32'((PRE_BITS + 32) * SPS));
        checkOutput("two_word_tready_active", 32'(tready_act - t0), 32'd1);
        checkOutput("two_word_done_count", 32'(done_count - d0), 32'd1);
        checkOutput("two_word_done_cycle", 32'(last_done_cyc - hs), 32'((PRE_BITS + 64) * SPS));

        // Underrun: second word arrives late and becomes its own frame.
        modelFrameStart(); modelWord(32'hFFFF_FFFF, 4'b1111);
        base = got_bits.size(); d0 = done_count;
        applyStimulus(32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b0, hs);
        waitFrameEnd();
        checkBits("underrun", base);
        checkOutput("underrun_flag", 32'(underrun_err), 32'd1);
        checkOutput("underrun_no_done", 32'(done_count - d0), 32'd0);
        repeat (10) @(negedge clk);
        modelFrameStart(); modelWord(32'h0000_0000, 4'b1111);
        base = got_bits.size(); d0 = done_count;
        applyStimulus(32'h0000_0000, 4'b1111, 1'b1, 1'b0, hs);
        waitFrameEnd();
        checkBits("late_word", base);
        checkOutput("late_word_done", 32'(done_count - d0), 32'd1);
        checkOutput("underrun_sticky", 32'(underrun_err), 32'd1);
        clearErrors();
        checkOutput("underrun_cleared", 32'(underrun_err), 32'd0);

        // Non-contiguous tkeep is sent as a full word and flagged.
        modelFrameStart(); modelWord(32'h1234_5678, 4'b0101);
        base = got_bits.size();
        applyStimulus(32'h1234_5678, 4'b0101, 1'b1, 1'b0, hs);
        waitFrameEnd();
        checkBits("keep0101", base);
        checkOutput("tkeep_err_set", 32'(tkeep_err), 32'd1);
        clearErrors();
        checkOutput("tkeep_err_cleared", 32'(tkeep_err), 32'd0);
        modelFrameStart(); modelWord(32'h8000_0001, 4'b0000);
        base = got_bits.size();
        applyStimulus(32'h8000_0001, 4'b0000, 1'b1, 1'b1, hs);
        waitFrameEnd();
        checkBits("keep0000", base);
        checkOutput("tkeep_set_beats_clr", 32'(tkeep_err), 32'd1);

        // Reset in the middle of a frame aborts silently.
        d0 = done_count; s0 = strobe_count;
        applyStimulus(32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0, hs);
        n = 0;
        while (strobe_count - s0 < 5 && n < 200) begin @(negedge clk); n++; end
        mod_reset = 1'b1;
        @(negedge clk);
        checkOutput("midframe_reset_outputs",
                    32'({bit_out, sym_strobe, tx_active, frame_done, underrun_err, tkeep_err, tready}), 32'd0);
        mod_reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midframe_reset_no_done", 32'(done_count - d0), 32'd0);
        checkOutput("midframe_reset_no_underrun", 32'(underrun_err), 32'd0);
        modelFrameStart(); modelWord(32'h0000_00A5, 4'b0001);
        base = got_bits.size(); d0 = done_count;
        applyStimulus(32'h0000_00A5, 4'b0001, 1'b1, 1'b0, hs);
        waitFrameEnd();
        checkBits("after_reset", base);
        checkOutput("after_reset_done", 32'(done_count - d0), 32'd1);

        // Random frames of 1..3 words with random tkeep, tvalid held high.
        for (int f = 0; f < 6; f++) begin
            clearErrors();
            modelFrameStart();
            bad = 1'b0;
            nw = $urandom_range(1, 3);
            base = got_bits.size(); d0 = done_count; a0 = act_cycles;
            for (int w = 0; w < nw; w++) begin
                d = $urandom;
                k = keep_opts[$urandom_range(0, 5)];
                modelWord(d, k);
                bad = bad | badKeep(k);
                applyStimulus(d, k, 1'(w == nw - 1), 1'b0, hs2);
                if (w == 0) hs = hs2;
            end
            waitFrameEnd();
            checkBits($sformatf("rand%0d", f), base);
            checkOutput($sformatf("rand%0d_tkeep_err", f), 32'(tkeep_err), 32'(bad));
            checkOutput($sformatf("rand%0d_done", f), 32'(done_count - d0), 32'd1);
            checkOutput($sformatf("rand%0d_active", f), 32'(act_cycles - a0), 32'(exp_bits.size() * SPS));
            checkOutput($sformatf("rand%0d_underrun", f), 32'(underrun_err), 32'd0);
        end

        checkOutput("strobe_spacing", 32'(gap_errs), 32'd0);
        checkOutput("bit_hold", 32'(hold_errs), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
